// File: rtl/block_allocator_if.sv
// Request/free/status bundle between a client and the block allocator.
// The client side is the master; the allocator is the slave.
interface block_allocator_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 6
);
  logic              alloc_req;
  logic              alloc_busy;
  logic              alloc_done;
  logic              alloc_fail;
  logic [ADDR_W-1:0] alloc_addr;
  logic              free_req;
  logic [ADDR_W-1:0] free_addr;
  logic              free_err;
  logic [CNT_W-1:0]  free_count;
  logic              hdr_wren;
  logic [ADDR_W-1:0] hdr_addr;
  logic [31:0]       hdr_data;

  modport master (
    output alloc_req, free_req, free_addr,
    input  alloc_busy, alloc_done, alloc_fail, alloc_addr,
    input  free_err, free_count, hdr_wren, hdr_addr, hdr_data
  );

  modport slave (
    input  alloc_req, free_req, free_addr,
    output alloc_busy, alloc_done, alloc_fail, alloc_addr,
    output free_err, free_count, hdr_wren, hdr_addr, hdr_data
  );
endinterface

// File: rtl/block_allocator.sv
// Fixed-size block allocator: used-bitmap with next-fit scan (one block per clock),
// validated frees, a free-block counter and a RAM header write strobe per grant.
module block_allocator #(
  parameter int NUM_BLOCKS   = 32,
  parameter int BLOCK_WORDS  = 32,
  parameter int ADDR_W       = 10,
  parameter int RESERVE_ZERO = 1
) (
  input  logic              clock,
  input  logic              resetn,
  block_allocator_if.slave  bus
);
  localparam int CNT_W = $clog2(NUM_BLOCKS + 1);
  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam logic [ADDR_W-1:0]     OFF_MASK  = ADDR_W'(BLOCK_WORDS - 1);
  localparam logic [NUM_BLOCKS-1:0] USED_RST  = NUM_BLOCKS'(RESERVE_ZERO != 0);
  localparam logic [IDX_W-1:0]      PTR_RST   = IDX_W'(RESERVE_ZERO != 0);
  localparam logic [CNT_W-1:0]      COUNT_RST = CNT_W'(NUM_BLOCKS - ((RESERVE_ZERO != 0) ? 1 : 0));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t                state_q;
  logic [NUM_BLOCKS-1:0] used_q, used_d;
  logic [IDX_W-1:0]      ptr_q, ptr_nxt_s;
  logic [IDX_W-1:0]      scanned_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  busy_q, done_q, fail_q, ferr_q;
  logic                  grant_s, free_ok_s;
  logic [ADDR_W-1:0]     free_idx_full_s;
  logic [IDX_W-1:0]      free_idx_s;

  // Free validation, grant detection and next bitmap/counter; SCAN sees only the pre-edge bitmap.
  always_comb begin
    free_idx_full_s = bus.free_addr >> OFF_W;
    free_idx_s      = free_idx_full_s[IDX_W-1:0];
    if (ptr_q == IDX_W'(NUM_BLOCKS - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = ptr_q + IDX_W'(1);
    end
    grant_s = (state_q == SCAN) && !used_q[ptr_q];
    if (bus.free_req && ((bus.free_addr & OFF_MASK) == '0) &&
        (32'(free_idx_full_s) < NUM_BLOCKS) && used_q[free_idx_s] &&
        !((RESERVE_ZERO != 0) && (free_idx_s == '0))) begin
      free_ok_s = 1'b1;
    end else begin
      free_ok_s = 1'b0;
    end
    used_d = used_q;
    if (free_ok_s) begin
      used_d[free_idx_s] = 1'b0;
    end else begin
      used_d[free_idx_s] = used_q[free_idx_s];
    end
    if (grant_s) begin
      used_d[ptr_q] = 1'b1;
    end else begin
      used_d[ptr_q] = used_d[ptr_q];
    end
    count_d = count_q + CNT_W'(free_ok_s) - CNT_W'(grant_s);
  end

  // Allocation FSM with all outputs registered alongside it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      used_q    <= USED_RST;
      ptr_q     <= PTR_RST;
      scanned_q <= '0;
      count_q   <= COUNT_RST;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      used_q  <= used_d;
      count_q <= count_d;
      ferr_q  <= bus.free_req && !free_ok_s;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.alloc_req) begin
            busy_q <= 1'b1;
            if (count_q == '0) begin
              state_q <= FAIL;
            end else begin
              state_q   <= SCAN;
              scanned_q <= '0;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        SCAN: begin
          ptr_q <= ptr_nxt_s;
          if (grant_s) begin
            addr_q  <= ADDR_W'(ptr_q) << OFF_W;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (scanned_q == IDX_W'(NUM_BLOCKS - 1)) begin
            // Every block seen used; only reachable if the counter disagrees with the bitmap.
            state_q <= FAIL;
          end else begin
            scanned_q <= scanned_q + IDX_W'(1);
          end
        end
        FAIL: begin
          fail_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.alloc_busy = busy_q;
  assign bus.alloc_done = done_q;
  assign bus.alloc_fail = fail_q;
  assign bus.alloc_addr = addr_q;
  assign bus.free_err   = ferr_q;
  assign bus.free_count = count_q;
  assign bus.hdr_wren   = done_q;
  assign bus.hdr_addr   = addr_q;
  assign bus.hdr_data   = 32'h8000_0000;
endmodule
